// File: rtl/tick_sched_pkg.sv
// Shared types and constants for the tick_sched clock-enable scheduler.
// TICK_SCHED_FORCE_EN (optional) adds a forced-apply config bit; nothing here depends on it.
package tick_sched_pkg;

  localparam int DIV_W_DFLT = 16;
  localparam int CH_IDX_W   = 4;

  // The slot holds div at the package width; narrower DIV_W values are zero-extended into it.
  typedef struct packed {
    logic [CH_IDX_W-1:0]   ch;
    logic [DIV_W_DFLT-1:0] div;
    logic                  en;
  } tick_cfg_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } slot_state_t;

endpackage

// File: rtl/tick_sched_if.sv
// Config request channel for tick_sched (valid/ready plus payload).
// With TICK_SCHED_FORCE_EN defined, the channel also carries cfg_force.
interface tick_sched_if
  import tick_sched_pkg::*;
#(
  parameter int DIV_W = DIV_W_DFLT
);

  logic                cfg_valid;
  logic                cfg_ready;
  logic [CH_IDX_W-1:0] cfg_ch;
  logic [DIV_W-1:0]    cfg_div;
  logic                cfg_en;

`ifdef TICK_SCHED_FORCE_EN
  logic                cfg_force;

  modport master (output cfg_valid, cfg_ch, cfg_div, cfg_en, cfg_force, input cfg_ready);
  modport slave  (input cfg_valid, cfg_ch, cfg_div, cfg_en, cfg_force, output cfg_ready);
`else
  modport master (output cfg_valid, cfg_ch, cfg_div, cfg_en, input cfg_ready);
  modport slave  (input cfg_valid, cfg_ch, cfg_div, cfg_en, output cfg_ready);
`endif

endinterface

// File: rtl/tick_sched_chan.sv
// One tick_sched channel: programmable divider producing a tick strobe and a 50% square wave.
// force_ld is only driven high when the top is built with TICK_SCHED_FORCE_EN.
module tick_chan #(
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 0
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             pre_tick,
  input  logic             apply,
  input  logic             force_ld,
  input  logic [DIV_W-1:0] new_div,
  input  logic             new_en,
  output logic             tick,
  output logic             clk_out,
  output logic             wrap,
  output logic             en
);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] cnt_q;
  logic             en_q;

  assign wrap = en_q && pre_tick && (cnt_q == div_q);
  assign en   = en_q;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      div_q   <= DIV_W'(DEFAULT_DIV);
      cnt_q   <= '0;
      en_q    <= 1'b0;
      tick    <= 1'b0;
      clk_out <= 1'b0;
    end else if (apply && force_ld) begin
      // Forced load restarts the channel from a clean phase without a strobe.
      div_q   <= new_div;
      en_q    <= new_en;
      cnt_q   <= '0;
      tick    <= 1'b0;
      clk_out <= 1'b0;
    end else begin
      tick <= wrap;
      if (!en_q) begin
        cnt_q   <= '0;
        clk_out <= 1'b0;
      end else if (pre_tick) begin
        if (cnt_q == div_q) begin
          cnt_q   <= '0;
          clk_out <= ~clk_out;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
      // Boundary apply: the wrap's own tick/toggle above still takes effect.
      if (apply) begin
        div_q <= new_div;
        en_q  <= new_en;
        cnt_q <= '0;
        if (!new_en) begin
          clk_out <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/tick_sched.sv
// tick_sched top: shared prescaler, single pending config slot and per-channel dividers.
// Build with TICK_SCHED_FORCE_EN to add cfg_force (apply immediately, restart phase).
module tick_sched
  import tick_sched_pkg::*;
#(
  parameter int NCH         = 4,
  parameter int DIV_W       = DIV_W_DFLT,
  parameter int PRESCALE    = 4,
  parameter int DEFAULT_DIV = 0
) (
  input  logic           clk_in,
  input  logic           rst,
  tick_sched_if.slave    cfg,
  output logic [NCH-1:0] tick,
  output logic [NCH-1:0] clk_out,
  output logic           busy
);

  // state   | meaning
  // ST_IDLE | slot empty, cfg_ready high (outside reset)
  // ST_PEND | slot holds a config waiting for its channel boundary

  localparam int PCNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PCNT_W-1:0] pcnt;
  logic              pre_tick;
  slot_state_t       state_q;
  slot_state_t       state_d;
  tick_cfg_t         slot_q;
  logic              take;
  logic              force_q;
  logic [NCH-1:0]    hit;
  logic [NCH-1:0]    apply;
  logic [NCH-1:0]    wrap;
  logic [NCH-1:0]    ch_en;

  assign pre_tick = (pcnt == PCNT_W'(PRESCALE - 1));

  always_ff @(posedge clk_in) begin
    if (rst) begin
      pcnt <= '0;
    end else if (pre_tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (take) begin
      slot_q <= '{ch: cfg.cfg_ch, div: DIV_W_DFLT'(cfg.cfg_div), en: cfg.cfg_en};
    end
  end

`ifdef TICK_SCHED_FORCE_EN
  always_ff @(posedge clk_in) begin
    if (rst) begin
      force_q <= 1'b0;
    end else if (take) begin
      force_q <= cfg.cfg_force;
    end
  end
`else
  assign force_q = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    cfg.cfg_ready = 1'b0;
    busy          = 1'b0;
    take          = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cfg.cfg_ready = !rst;
        take          = cfg.cfg_valid && !rst;
        if (take) begin
          state_d = ST_PEND;
        end
      end
      ST_PEND: begin
        busy = 1'b1;
        // An out-of-range channel matches no hit bit and is simply dropped.
        if ((|apply) || !(|hit)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign hit[i]   = (state_q == ST_PEND) && (slot_q.ch == CH_IDX_W'(i));
    assign apply[i] = hit[i] && (force_q || !ch_en[i] || wrap[i]);

    tick_chan #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clk_in   (clk_in),
      .rst      (rst),
      .pre_tick (pre_tick),
      .apply    (apply[i]),
      .force_ld (force_q),
      .new_div  (DIV_W'(slot_q.div)),
      .new_en   (slot_q.en),
      .tick     (tick[i]),
      .clk_out  (clk_out[i]),
      .wrap     (wrap[i]),
      .en       (ch_en[i])
    );
  end

endmodule

// File: tb/tb_tick_sched.sv
// Self-checking bench for tick_sched: directed scenarios plus random config traffic
// compared every cycle against a pre_tick-countdown reference model.
module tb_tick_sched;
  import tick_sched_pkg::*;

  localparam int NCH         = 4;
  localparam int DIV_W       = 16;
  localparam int PRESCALE    = 4;
  localparam int DEFAULT_DIV = 0;

  logic           clk_in = 1'b0;
  logic           rst;
  logic [NCH-1:0] tick;
  logic [NCH-1:0] clk_out;
  logic           busy;

  tick_sched_if #(.DIV_W(DIV_W)) bus ();

  tick_sched #(
    .NCH         (NCH),
    .DIV_W       (DIV_W),
    .PRESCALE    (PRESCALE),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) dut (
    .clk_in  (clk_in),
    .rst     (rst),
    .cfg     (bus),
    .tick    (tick),
    .clk_out (clk_out),
    .busy    (busy)
  );

  always #5 clk_in = ~clk_in;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: each enabled channel counts down the pre_ticks left until its next tick.
  int m_pcnt;
  bit m_pend;
  int m_pch;
  int m_pdiv;
  bit m_pen;
  bit m_en   [NCH];
  int m_div  [NCH];
  int m_rem  [NCH];
  bit m_clk  [NCH];
  bit m_tick [NCH];

  int cyc       = 0;
  bit per_chk   = 1'b0;
  int per_exp   = 0;
  int last_t0   = -1;

  function automatic bit m_ready();
    return !m_pend && !rst;
  endfunction

  task automatic model_edge();
    bit pre;
    bit acc;
    bit wr [NCH];
    if (rst) begin
      m_pcnt = 0;
      m_pend = 1'b0;
      for (int i = 0; i < NCH; i++) begin
        m_en[i] = 1'b0; m_div[i] = DEFAULT_DIV; m_rem[i] = 0; m_clk[i] = 1'b0; m_tick[i] = 1'b0;
      end
      return;
    end
    pre    = (m_pcnt == PRESCALE - 1);
    acc    = bus.cfg_valid && !m_pend;
    m_pcnt = (m_pcnt + 1) % PRESCALE;
    for (int i = 0; i < NCH; i++) begin
      wr[i]     = m_en[i] && pre && (m_rem[i] == 1);
      m_tick[i] = wr[i];
      if (m_en[i] && pre) begin
        if (wr[i]) begin
          m_rem[i] = m_div[i] + 1;
          m_clk[i] = !m_clk[i];
        end else begin
          m_rem[i]--;
        end
      end
    end
    if (m_pend) begin
      if (m_pch >= NCH) begin
        m_pend = 1'b0;
      end else if (!m_en[m_pch] || wr[m_pch]) begin
        m_en[m_pch]  = m_pen;
        m_div[m_pch] = m_pdiv;
        m_rem[m_pch] = m_pdiv + 1;
        if (!m_pen) m_clk[m_pch] = 1'b0;
        m_pend = 1'b0;
      end
    end
    if (acc) begin
      m_pend = 1'b1;
      m_pch  = int'(bus.cfg_ch);
      m_pdiv = int'(bus.cfg_div);
      m_pen  = bus.cfg_en;
    end
  endtask

  task automatic step();
    logic [NCH-1:0] et;
    logic [NCH-1:0] ec;
    model_edge();
    @(negedge clk_in);
    cyc++;
    for (int i = 0; i < NCH; i++) begin
      et[i] = m_tick[i];
      ec[i] = m_clk[i];
    end
    chk("tick", 32'(tick), 32'(et));
    chk("clk_out", 32'(clk_out), 32'(ec));
    chk("busy", 32'(busy), 32'(m_pend));
    chk("cfg_ready", 32'(bus.cfg_ready), 32'(m_ready()));
    if (per_chk && tick[0] === 1'b1) begin
      if (last_t0 >= 0) chk("ch0_period", 32'(cyc - last_t0), 32'(per_exp));
      last_t0 = cyc;
    end
  endtask

  task automatic idle(int n);
    repeat (n) step();
  endtask

  task automatic send(int ch, int div, bit en);
    bit rdy;
    bus.cfg_valid = 1'b1;
    bus.cfg_ch    = CH_IDX_W'(ch);
    bus.cfg_div   = DIV_W'(div);
    bus.cfg_en    = en;
    for (int k = 0; k < 200; k++) begin
      rdy = m_ready();
      step();
      if (rdy) begin
        bus.cfg_valid = 1'b0;
        bus.cfg_div   = DIV_W'($urandom);
        bus.cfg_en    = 1'($urandom);
        return;
      end
    end
    bus.cfg_valid = 1'b0;
    chk("send_timeout", 32'(bus.cfg_ready), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    bus.cfg_valid = 1'b0;
    bus.cfg_ch    = '0;
    bus.cfg_div   = '0;
    bus.cfg_en    = 1'b0;
`ifdef TICK_SCHED_FORCE_EN
    bus.cfg_force = 1'b0;
`endif

    // reset held three cycles, cfg_ready expected to rise right after
    idle(3);
    rst = 1'b0;
    idle(2);

    // enable ch0 from idle, div=2 -> tick every 12 clocks
    per_exp = 12;
    per_chk = 1'b1;
    send(0, 2, 1'b1);
    idle(60);
    per_chk = 1'b0;

    // ch1 running div=3, mid-period change with a second request back-pressured behind it
    send(1, 3, 1'b1);
    idle(23);
    send(1, 0, 1'b1);
    send(3, 1, 1'b1);
    idle(40);

    // disable a running channel, then an out-of-range channel
    send(2, 1, 1'b1);
    idle(10);
    send(2, 0, 1'b0);
    idle(20);
    send(9, 3, 1'b1);
    idle(6);

    // reset while a config is pending on a running channel
    send(0, 50, 1'b1);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(40);

    // random traffic
    repeat (300) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 7) begin
        send(int'($urandom_range(0, 5)), int'($urandom_range(0, 6)), ($urandom_range(0, 3) != 0));
      end else if (r == 7) begin
        rst = 1'b1;
        idle(int'($urandom_range(1, 2)));
        rst = 1'b0;
      end
      idle(int'($urandom_range(0, 15)));
    end
    idle(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
